// File: rtl/led_blink_sequencer_pkg.sv
// Shared state encoding and digit clamp constant for the LED blink sequencer.
package led_blink_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ON   = 3'd1,
        OFF  = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int MAX_DIGIT = 9;

endpackage

// File: rtl/led_blink_sequencer_tick_gen.sv
// Loadable-period tick divider: tick is high when the counter equals period,
// after which the counter restarts; clear forces it back to zero.
module led_tick_gen #(
    parameter int CNT_W = 26
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] count;

    assign tick = (count == period);

    always_ff @(posedge clock) begin
        if (reset || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/led_blink_sequencer.sv
// Blinks the result LED (digit+1) times, then a trailing gap, then pulses done.
// Build with LED_BLINK_REPEAT_EN to loop the pattern until stop instead.
module led_blink_sequencer
    import led_blink_sequencer_pkg::*;
#(
    parameter int CNT_W     = 26,
    parameter int DIGIT_W   = 4,
    parameter int GAP_TICKS = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [DIGIT_W-1:0] digit,
    input  logic [CNT_W-1:0]   on_count,
    input  logic [CNT_W-1:0]   off_count,
    input  logic               stop,
    output logic               busy,
    output logic               done,
    output logic               led,
    output logic [DIGIT_W-1:0] blink_idx
);

    localparam int GAP_W = $clog2(GAP_TICKS + 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   on_lat, on_lat_next;
    logic [CNT_W-1:0]   off_lat, off_lat_next;
    logic [DIGIT_W-1:0] digit_lat, digit_lat_next;
    logic [DIGIT_W-1:0] remaining, remaining_next;
    logic [DIGIT_W-1:0] blink_cnt, blink_cnt_next;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_next;
    logic [DIGIT_W-1:0] digit_clamped;
    logic [CNT_W-1:0]   period;
    logic               clear;
    logic               tick;

    assign digit_clamped = (digit > DIGIT_W'(MAX_DIGIT)) ? DIGIT_W'(MAX_DIGIT) : digit;

    led_tick_gen #(.CNT_W(CNT_W)) u_tick_gen (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear),
        .period (period),
        .tick   (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            on_lat    <= '0;
            off_lat   <= '0;
            digit_lat <= '0;
            remaining <= '0;
            blink_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_next;
            on_lat    <= on_lat_next;
            off_lat   <= off_lat_next;
            digit_lat <= digit_lat_next;
            remaining <= remaining_next;
            blink_cnt <= blink_cnt_next;
            gap_cnt   <= gap_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        on_lat_next    = on_lat;
        off_lat_next   = off_lat;
        digit_lat_next = digit_lat;
        remaining_next = remaining;
        blink_cnt_next = blink_cnt;
        gap_cnt_next   = gap_cnt;

        if (stop) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next     = ON;
                        on_lat_next    = on_count;
                        off_lat_next   = off_count;
                        digit_lat_next = digit_clamped;
                        remaining_next = digit_clamped;
                        blink_cnt_next = '0;
                    end
                end
                ON: begin
                    if (tick) begin
                        state_next     = OFF;
                        blink_cnt_next = blink_cnt + 1'b1;
                    end
                end
                OFF: begin
                    if (tick) begin
                        if (remaining != '0) begin
                            state_next     = ON;
                            remaining_next = remaining - 1'b1;
                        end else begin
                            state_next   = GAP;
                            gap_cnt_next = '0;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gap_cnt == GAP_W'(GAP_TICKS - 1)) begin
`ifdef LED_BLINK_REPEAT_EN
                            state_next     = ON;
                            remaining_next = digit_lat;
                            blink_cnt_next = '0;
`else
                            state_next = DONE;
`endif
                        end else begin
                            gap_cnt_next = gap_cnt + 1'b1;
                        end
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Counter restarts on every phase change and is held at zero outside the timed states.
    assign period    = (state == ON) ? on_lat : off_lat;
    assign clear     = (state_next != state) || (state == IDLE) || (state == DONE);

    assign busy      = (state == ON) || (state == OFF) || (state == GAP);
    assign done      = (state == DONE);
    assign led       = (state == ON);
    assign blink_idx = blink_cnt;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Self-checking bench: table of whole-pattern vectors, directed corner sequences,
// and random patterns against a per-cycle model built from the blink rules.
module tb_led_blink_sequencer;

    localparam int CNT_W     = 26;
    localparam int DIGIT_W   = 4;
    localparam int GAP_TICKS = 4;
    localparam int OW        = 3 + DIGIT_W;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [DIGIT_W-1:0] digit = '0;
    logic [CNT_W-1:0]   on_count = '0;
    logic [CNT_W-1:0]   off_count = '0;
    logic               stop = 1'b0;
    logic               busy, done, led;
    logic [DIGIT_W-1:0] blink_idx;

    int checks = 0;
    int errors = 0;
    logic [OW-1:0] exp_q[$];

    led_blink_sequencer #(.CNT_W(CNT_W), .DIGIT_W(DIGIT_W), .GAP_TICKS(GAP_TICKS)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .digit     (digit),
        .on_count  (on_count),
        .off_count (off_count),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .led       (led),
        .blink_idx (blink_idx)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [OW-1:0] pack(input bit b, input bit l, input bit d, input int idx);
        return {b, l, d, DIGIT_W'(idx)};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {busy, led, done, blink_idx};
    endfunction

    task automatic check_vec(input string name, input int c, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got busy=%b led=%b done=%b idx=%0d, want busy=%b led=%b done=%b idx=%0d",
                     name, c, act[OW-1], act[OW-2], act[OW-3], act[DIGIT_W-1:0],
                     exp[OW-1], exp[OW-2], exp[OW-3], exp[DIGIT_W-1:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Model: each blink is (on+1) lit cycles then (off+1) dark cycles, followed by
    // GAP_TICKS off periods; the index counts blinks whose lit phase has ended.
    task automatic build_expected(input int d, input int on, input int off, input int reps, input bit single);
        int dc;
        dc = (d > 9) ? 9 : d;
        exp_q.delete();
        for (int r = 0; r < reps; r++) begin
            for (int b = 0; b <= dc; b++) begin
                repeat (on + 1)  exp_q.push_back(pack(1, 1, 0, b));
                repeat (off + 1) exp_q.push_back(pack(1, 0, 0, b + 1));
            end
            repeat (GAP_TICKS * (off + 1)) exp_q.push_back(pack(1, 0, 0, dc + 1));
        end
        if (single) begin
            exp_q.push_back(pack(0, 0, 1, dc + 1));
            exp_q.push_back(pack(0, 0, 0, dc + 1));
        end
    endtask

    // Called at a negedge; start is driven in this cycle, outputs compared from the next.
    task automatic run_model(input string name, input int d, input int on, input int off,
                             input int reps, input bit single, input bit disturb);
        int c;
        logic [OW-1:0] e;
        build_expected(d, on, off, reps, single);
        digit     = DIGIT_W'(d);
        on_count  = CNT_W'(on);
        off_count = CNT_W'(off);
        start     = 1'b1;
        c = 0;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            c++;
            e = exp_q.pop_front();
            check_vec(name, c, obs(), e);
            start = disturb && (c == 5);
            if (disturb && c == 2) on_count = CNT_W'(9);
        end
        start = 1'b0;
    endtask

    typedef struct {
        int d;
        int on;
        int off;
        int pulses;
        int done_cyc;
    } vec_t;

    task automatic run_vector(input vec_t v);
        int c, pulses, done_cyc, done_cnt, idx_at_done;
        bit prev_led;
        digit     = DIGIT_W'(v.d);
        on_count  = CNT_W'(v.on);
        off_count = CNT_W'(v.off);
        start     = 1'b1;
        c = 0; pulses = 0; done_cyc = -1; done_cnt = 0; idx_at_done = -1; prev_led = 1'b0;
        while (c < 300 && !(done_cyc >= 0 && c >= done_cyc + 2)) begin
            @(negedge clock);
            c++;
            start = 1'b0;
            if (led && !prev_led) pulses++;
            prev_led = led;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    idx_at_done = int'(blink_idx);
                    check_int($sformatf("vec d=%0d busy at done", v.d), int'(busy), 0);
                end
            end
        end
        check_int($sformatf("vec d=%0d pulses", v.d), pulses, v.pulses);
        check_int($sformatf("vec d=%0d done cycle", v.d), done_cyc, v.done_cyc);
        check_int($sformatf("vec d=%0d done count", v.d), done_cnt, 1);
        check_int($sformatf("vec d=%0d blink_idx", v.d), idx_at_done, v.pulses);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{d: 2,  on: 2, off: 1, pulses: 3,  done_cyc: 24};
        vecs[1] = '{d: 15, on: 0, off: 0, pulses: 10, done_cyc: 25};
        vecs[2] = '{d: 0,  on: 0, off: 0, pulses: 1,  done_cyc: 7};
        vecs[3] = '{d: 0,  on: 3, off: 2, pulses: 1,  done_cyc: 20};
        vecs[4] = '{d: 9,  on: 1, off: 0, pulses: 10, done_cyc: 35};
        vecs[5] = '{d: 10, on: 0, off: 1, pulses: 10, done_cyc: 39};

        // Reset dominates a concurrent start request.
        start = 1'b1;
        repeat (3) @(negedge clock);
        check_vec("reset", 0, obs(), pack(0, 0, 0, 0));
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);

`ifndef LED_BLINK_REPEAT_EN
        for (int i = 0; i < 6; i++) run_vector(vecs[i]);

        run_model("first_scenario", 2, 2, 1, 1, 1, 0);
        run_model("start_while_busy", 2, 2, 1, 1, 1, 1);
        run_model("clamp", 15, 0, 0, 1, 1, 0);

        // Stop mid-pattern, then restart two cycles later.
        digit = 4'd2; on_count = 26'd2; off_count = 26'd1; start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            start = 1'b0;
            check_int($sformatf("stop_pre led c%0d", c), int'(led), (c <= 3 || c >= 6) ? 1 : 0);
        end
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        check_vec("stop", 8, obs() & ~OW'(DIGIT_W'('1)), pack(0, 0, 0, 0));
        @(negedge clock);
        check_vec("stop_idle", 9, obs() & ~OW'(DIGIT_W'('1)), pack(0, 0, 0, 0));
        @(negedge clock);
        run_model("restart_after_stop", 2, 2, 1, 1, 1, 0);

        // Reset mid-pattern: clean idle next cycle and no late done.
        start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_vec("reset_mid", 8, obs(), pack(0, 0, 0, 0));
        begin
            int seen;
            seen = 0;
            repeat (30) begin
                @(negedge clock);
                if (done || led || busy) seen++;
            end
            check_int("reset_mid activity after", seen, 0);
        end

        for (int i = 0; i < 10; i++) begin
            run_model($sformatf("random%0d", i), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1, 1, 0);
        end
`else
        // Pattern repeats back to back; second pattern begins at cycle 24.
        run_model("repeat", 2, 2, 1, 2, 0, 0);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        check_vec("repeat_stop", 47, obs() & ~OW'(DIGIT_W'('1)), pack(0, 0, 0, 0));
        begin
            int seen;
            seen = 0;
            repeat (30) begin
                @(negedge clock);
                if (done || led || busy) seen++;
            end
            check_int("repeat activity after stop", seen, 0);
        end
        run_model("repeat_rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 2, 0, 0);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        check_vec("repeat_rand_stop", 0, obs() & ~OW'(DIGIT_W'('1)), pack(0, 0, 0, 0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
